// File: rtl/lane_serializer_pkg.sv
// Shared phy-lane definitions: byte width, comma symbol and serializer FSM encoding.
// The comma value is shared with the receiver's comma detector.
package lane_serializer_pkg;

    // Width of one lane symbol.
    localparam int unsigned BYTE_W = 8;

    // Bit-counter width needed to index one symbol.
    localparam int unsigned BIT_CNT_W = $clog2(BYTE_W);

    // Default comma / idle symbol.
    localparam logic [BYTE_W-1:0] IDLE_CHAR_DEF = 8'hBC;

    // Serializer state: SYNC sends the training run, RUN accepts data.
    typedef enum logic {
        StSync = 1'b0,
        StRun  = 1'b1
    } ser_state_e;

endpackage

// File: rtl/lane_serializer_if.sv
// Byte-side handshake plus lane outputs of one transmit lane serializer.
// master: the upstream byte source / observer; slave: the serializer itself.
interface lane_serializer_if;
    import lane_serializer_pkg::*;

    logic [BYTE_W-1:0] data_in;
    logic              valid_in;
    logic              ready_out;
    logic              serial_out;
    logic              data_flag;
    logic              active_out;

    modport master (
        output data_in,
        output valid_in,
        input  ready_out,
        input  serial_out,
        input  data_flag,
        input  active_out
    );

    modport slave (
        input  data_in,
        input  valid_in,
        output ready_out,
        output serial_out,
        output data_flag,
        output active_out
    );

endinterface

// File: rtl/lane_serializer.sv
// Transmit lane serializer: turns a valid-qualified byte stream into an MSB-first
// bit stream. After reset it sends SYNC_COUNT commas for receiver byte alignment,
// then sends data bytes when offered and commas otherwise.
module lane_serializer
    import lane_serializer_pkg::*;
#(
    parameter logic [BYTE_W-1:0] IDLE_CHAR  = IDLE_CHAR_DEF,
    parameter int unsigned       SYNC_COUNT = 4
) (
    input  logic             clk_32f,
    input  logic             reset_L,
    lane_serializer_if.slave bus
);

    // sync_cnt only needs to hold 0..SYNC_COUNT-1; it clears on the last comma.
    localparam int unsigned SyncW = (SYNC_COUNT > 1) ? $clog2(SYNC_COUNT) : 1;
    localparam logic [SyncW-1:0]     SyncLast = SyncW'(SYNC_COUNT - 1);
    localparam logic [BIT_CNT_W-1:0] LastBit  = BIT_CNT_W'(BYTE_W - 1);

    logic [BIT_CNT_W-1:0] r_bit_cnt;
    logic [BYTE_W-1:0]    r_shift_reg;
    logic [SyncW-1:0]     r_sync_cnt;
    logic                 r_data_flag;
    ser_state_e           r_state;

    logic                 w_load;
    logic                 w_run;

    // Load edge: the bit counter sits on the last bit of the current symbol.
    always_comb begin
        w_load = (r_bit_cnt == LastBit);
        w_run  = (r_state == StRun);
    end

    // Bit counter, shift register and SYNC/RUN sequencing share one register block.
    always_ff @(posedge clk_32f or negedge reset_L) begin
        if (!reset_L) begin
            r_bit_cnt   <= LastBit;
            r_shift_reg <= '0;
            r_sync_cnt  <= '0;
            r_data_flag <= 1'b0;
            r_state     <= StSync;
        end else begin
            r_bit_cnt <= r_bit_cnt + BIT_CNT_W'(1);
            if (w_load) begin
                case (r_state)
                    StSync: begin
                        r_shift_reg <= IDLE_CHAR;
                        r_data_flag <= 1'b0;
                        if (r_sync_cnt == SyncLast) begin
                            r_state    <= StRun;
                            r_sync_cnt <= '0;
                        end else begin
                            r_sync_cnt <= r_sync_cnt + SyncW'(1);
                        end
                    end
                    StRun: begin
                        // No escaping: a data byte equal to the comma still flags as data.
                        if (bus.valid_in) begin
                            r_shift_reg <= bus.data_in;
                            r_data_flag <= 1'b1;
                        end else begin
                            r_shift_reg <= IDLE_CHAR;
                            r_data_flag <= 1'b0;
                        end
                    end
                    default: begin
                        r_shift_reg <= IDLE_CHAR;
                        r_data_flag <= 1'b0;
                        r_state     <= StSync;
                        r_sync_cnt  <= '0;
                    end
                endcase
            end else begin
                r_shift_reg <= {r_shift_reg[BYTE_W-2:0], 1'b0};
            end
        end
    end

    // Lane outputs: serial_out comes straight from a flop; ready_out is the only
    // combinational output and depends on state only, never on inputs.
    always_comb begin
        bus.serial_out = r_shift_reg[BYTE_W-1];
        bus.data_flag  = r_data_flag;
        bus.active_out = w_run;
        bus.ready_out  = w_run && w_load;
    end

endmodule
